// File: rtl/saw_pkg.sv
// saw_pkg: shared Stop-and-Wait ARQ definitions used by the transmitter and receiver.
package saw_pkg;
   localparam int SEQ_W_DEF  = 1;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHECK   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_ACK     = 2'd3
   } rx_state_e;
   typedef struct packed {
      logic [SEQ_W_DEF-1:0]  seq;
      logic [DATA_W_DEF-1:0] data;
      logic                  err;
   } frame_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;
   always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
   always_ff @(posedge clk) begin
      if (!rstn) count_q <= '0;
      else       count_q <= count_d;
   end
   assign count = count_q;
endmodule

// File: rtl/fsm_saw_receiver.sv
// fsm_saw_receiver: Stop-and-Wait ARQ receiver; checks frames, delivers in-order payloads
// and returns cumulative ACKs carrying the next expected sequence number.
import saw_pkg::*;
module fsm_saw_receiver #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEQ_W  = SEQ_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              frm_valid,
   input  logic [SEQ_W-1:0]  frm_seq,
   input  logic [DATA_W-1:0] frm_data,
   input  logic              frm_err,
   output logic              deliver_valid,
   output logic [DATA_W-1:0] deliver_data,
   input  logic              deliver_ready,
   output logic              ack_send,
   output logic [SEQ_W-1:0]  ack_seq,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  dup_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);
   rx_state_e         state_q, state_d;
   logic [SEQ_W-1:0]  rn_q, rn_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_inc, dup_inc, drop_inc;
   always_comb begin
      state_d = state_q;
      rn_d    = rn_q;
      seq_d   = seq_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (frm_valid && !frm_err) begin
               seq_d   = frm_seq;
               data_d  = frm_data;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK:   state_d = (seq_q == rn_q) ? ST_DELIVER : ST_ACK;
         ST_DELIVER: begin
            if (deliver_ready) begin
               rn_d    = rn_q + 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         rn_q    <= '0;
         seq_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rn_q    <= rn_d;
         seq_q   <= seq_d;
         data_q  <= data_d;
      end
   end
   // Any frame arriving outside IDLE is lost; its error flag is irrelevant.
   assign err_inc  = (state_q == ST_IDLE) && frm_valid && frm_err;
   assign dup_inc  = (state_q == ST_CHECK) && (seq_q != rn_q);
   assign drop_inc = (state_q != ST_IDLE) && frm_valid;
   assign deliver_valid = (state_q == ST_DELIVER);
   assign deliver_data  = data_q;
   assign ack_send      = (state_q == ST_ACK);
   assign ack_seq       = rn_q;
   sat_counter #(.CNT_W(CNT_W)) u_err_cnt  (.clk(clk), .rstn(rstn), .inc(err_inc),  .count(err_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_dup_cnt  (.clk(clk), .rstn(rstn), .inc(dup_inc),  .count(dup_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (.clk(clk), .rstn(rstn), .inc(drop_inc), .count(drop_cnt));
endmodule

// File: tb/tb_fsm_saw_receiver.sv
// tb_fsm_saw_receiver: directed and random stimulus against a frame-lifetime model of the receiver.
module tb_fsm_saw_receiver;
   logic       clk = 1'b0, rstn = 1'b0;
   logic       frm_valid = 1'b0, frm_err = 1'b0, deliver_ready = 1'b0;
   logic [0:0] frm_seq = '0;
   logic [7:0] frm_data = '0;
   logic       deliver_valid, ack_send;
   logic [7:0] deliver_data, err_cnt, dup_cnt, drop_cnt;
   logic [0:0] ack_seq;
   int n_chk = 0, n_fail = 0;
   fsm_saw_receiver dut (
      .clk(clk), .rstn(rstn), .frm_valid(frm_valid), .frm_seq(frm_seq), .frm_data(frm_data),
      .frm_err(frm_err), .deliver_valid(deliver_valid), .deliver_data(deliver_data),
      .deliver_ready(deliver_ready), .ack_send(ack_send), .ack_seq(ack_seq),
      .err_cnt(err_cnt), .dup_cnt(dup_cnt), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   // Model: a frame in flight is tracked by its age in cycles since acceptance.
   bit         mon_en = 0, m_active = 0, m_good = 0, m_deliv = 0;
   int         m_age = 0, m_rn = 0, m_err = 0, m_dup = 0, m_drop = 0;
   logic [7:0] m_data = '0;
   function automatic bit e_valid();
      return m_active && m_good && m_age >= 2 && !m_deliv;
   endfunction
   function automatic bit e_ack();
      return m_active && (m_good ? m_deliv : m_age == 2);
   endfunction
   function automatic int sat(input int v);
      return v > 255 ? 255 : v;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   always @(posedge clk) begin
      if (!rstn) begin
         mon_en = 1; m_active = 0; m_rn = 0; m_err = 0; m_dup = 0; m_drop = 0; m_data = '0;
      end else if (m_active) begin
         if (frm_valid) m_drop = sat(m_drop + 1);
         if (e_ack()) m_active = 0;
         else begin
            if (e_valid() && deliver_ready) begin
               m_deliv = 1;
               m_rn = (m_rn + 1) % 2;
            end
            if (m_age == 1 && !m_good) m_dup = sat(m_dup + 1);
            m_age++;
         end
      end else if (frm_valid) begin
         if (frm_err) m_err = sat(m_err + 1);
         else begin
            m_active = 1; m_age = 1; m_good = (int'(frm_seq) == m_rn); m_deliv = 0; m_data = frm_data;
         end
      end
   end
   always @(negedge clk) begin
      if (mon_en) begin
         chk("m_valid", 32'(deliver_valid), 32'(e_valid()));
         chk("m_ack", 32'(ack_send), 32'(e_ack()));
         chk("m_ack_seq", 32'(ack_seq), m_rn);
         chk("m_data", 32'(deliver_data), 32'(m_data));
         chk("m_err_cnt", 32'(err_cnt), m_err);
         chk("m_dup_cnt", 32'(dup_cnt), m_dup);
         chk("m_drop_cnt", 32'(drop_cnt), m_drop);
      end
   end
   task automatic step();
      @(negedge clk);
   endtask
   task automatic send(input logic [0:0] s, input logic [7:0] d, input logic e);
      frm_valid = 1'b1; frm_seq = s; frm_data = d; frm_err = e;
      step();
      frm_valid = 1'b0; frm_err = 1'b0;
   endtask
   initial begin
      step(); step();
      chk("rst_valid", 32'(deliver_valid), 0);
      chk("rst_ack", 32'(ack_send), 0);
      chk("rst_ack_seq", 32'(ack_seq), 0);
      chk("rst_data", 32'(deliver_data), 0);
      chk("rst_err", 32'(err_cnt), 0);
      rstn = 1'b1; deliver_ready = 1'b1;
      step();
      send(1'b0, 8'hA5, 1'b0);
      chk("t1_valid_k1", 32'(deliver_valid), 0);
      step();
      chk("t1_valid_k2", 32'(deliver_valid), 1);
      chk("t1_data_k2", 32'(deliver_data), 32'hA5);
      step();
      chk("t1_ack_k3", 32'(ack_send), 1);
      chk("t1_ack_seq", 32'(ack_seq), 1);
      step();
      chk("t1_ack_k4", 32'(ack_send), 0);
      send(1'b0, 8'h11, 1'b0);
      step();
      chk("t2_valid", 32'(deliver_valid), 0);
      chk("t2_ack", 32'(ack_send), 1);
      chk("t2_ack_seq", 32'(ack_seq), 1);
      chk("t2_dup", 32'(dup_cnt), 1);
      step();
      send(1'b1, 8'h99, 1'b1);
      chk("t3_err", 32'(err_cnt), 1);
      chk("t3_rn", 32'(ack_seq), 1);
      step();
      chk("t3_no_ack", 32'(ack_send), 0);
      send(1'b1, 8'h3C, 1'b0);
      step();
      chk("t3_valid", 32'(deliver_valid), 1);
      chk("t3_data", 32'(deliver_data), 32'h3C);
      step();
      chk("t3_ack", 32'(ack_send), 1);
      chk("t3_wrap", 32'(ack_seq), 0);
      step();
      deliver_ready = 1'b0;
      send(1'b0, 8'h77, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_valid", 32'(deliver_valid), 1);
         chk("t4_stall_data", 32'(deliver_data), 32'h77);
         frm_valid = (i == 2); frm_seq = 1'($urandom); frm_data = 8'($urandom); frm_err = 1'($urandom);
         step();
      end
      frm_valid = 1'b0; frm_err = 1'b0; deliver_ready = 1'b1;
      chk("t4_drop", 32'(drop_cnt), 1);
      step();
      chk("t4_ack", 32'(ack_send), 1);
      chk("t4_ack_seq", 32'(ack_seq), 1);
      step();
      for (int i = 0; i < 300; i++) send(1'($urandom), 8'($urandom), 1'b1);
      chk("t5_err_sat", 32'(err_cnt), 255);
      deliver_ready = 1'b0;
      send(1'b1, 8'h5A, 1'b0);
      step();
      chk("t6_valid", 32'(deliver_valid), 1);
      rstn = 1'b0;
      step();
      chk("t6_valid_rst", 32'(deliver_valid), 0);
      chk("t6_ack_rst", 32'(ack_send), 0);
      chk("t6_rn_rst", 32'(ack_seq), 0);
      chk("t6_err_rst", 32'(err_cnt), 0);
      chk("t6_drop_rst", 32'(drop_cnt), 0);
      rstn = 1'b1;
      step();
      chk("t6_no_ack", 32'(ack_send), 0);
      for (int i = 0; i < 3000; i++) begin
         rstn = ($urandom_range(0, 199) != 0);
         frm_valid = ($urandom_range(0, 2) == 0);
         frm_seq = 1'($urandom);
         frm_data = 8'($urandom);
         frm_err = ($urandom_range(0, 3) == 0);
         deliver_ready = 1'($urandom);
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fsm_saw_receiver.md
# fsm_saw_receiver

Stop-and-Wait ARQ receiver state machine, the peer stage consuming frames produced by the SAW transmitter across the channel model. Checks each arriving frame for corruption and sequence order, delivers in-order payloads to the network layer over a valid/ready handshake, and issues a cumulative ACK carrying the next expected sequence number. Corrupted frames are silently discarded, so the transmitter's time-out resends them; duplicates are re-ACKed without delivery.

## Interface
- DATA_W, 8, payload width
- SEQ_W, 1, sequence/ACK number width; numbers wrap modulo 2^SEQ_W
- CNT_W, 8, width of saturating statistics counters
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- frm_valid  in  1  single-cycle pulse: frame present on frm_seq/frm_data/frm_err
- frm_seq  in  SEQ_W  sequence number of arriving frame
- frm_data  in  DATA_W  payload of arriving frame
- frm_err  in  1  frame corrupted (from upstream CRC check)
- deliver_valid  out  1  payload available to network layer
- deliver_data  out  DATA_W  payload, stable while deliver_valid=1
- deliver_ready  in  1  network layer accepts payload
- ack_send  out  1  single-cycle pulse: transmit ACK
- ack_seq  out  SEQ_W  ACK number = next expected sequence number Rn
- err_cnt  out  CNT_W  corrupted frames discarded, saturating
- dup_cnt  out  CNT_W  duplicate frames re-ACKed, saturating
- drop_cnt  out  CNT_W  frames arriving while busy, saturating

## Operation
- Internal: state, Rn (SEQ_W), seq_r (SEQ_W), data_r (DATA_W).
- States: IDLE, CHECK, DELIVER, ACK. Moore outputs decoded from state and registers.
- IDLE: frm_valid=1 and frm_err=1 -> err_cnt++, stay IDLE, no ACK. frm_valid=1 and frm_err=0 -> capture seq_r<=frm_seq, data_r<=frm_data, go CHECK. Otherwise stay.
- CHECK: seq_r==Rn -> DELIVER. seq_r!=Rn -> dup_cnt++, go ACK (Rn unchanged, re-ACK).
- DELIVER: deliver_valid=1, deliver_data=data_r. Hold until deliver_ready=1; on that cycle Rn<=Rn+1 (modulo 2^SEQ_W), go ACK.
- ACK: ack_send=1 for exactly one cycle, ack_seq=Rn; go IDLE.
- ack_seq always reflects Rn, in all states.
- frm_valid=1 in CHECK, DELIVER or ACK: frame dropped, drop_cnt++, no state effect (frm_err ignored).
- Counters saturate at 2^CNT_W-1, never wrap.
- Unused state encodings -> IDLE.

## Timing
- Reset (rstn=0 at posedge): state=IDLE, Rn=0, seq_r=0, data_r=0, all counters 0; deliver_valid=0, deliver_data=0, ack_send=0, ack_seq=0. Reset mid-operation aborts any pending delivery/ACK with no ACK emitted.
- Good in-order frame sampled at edge k: CHECK in cycle k+1, deliver_valid=1 from cycle k+2; with deliver_ready=1 in k+2, ack_send=1 in cycle k+3 with the incremented Rn, IDLE in k+4. Minimum frame-to-ACK latency 3 cycles.
- Each stall cycle of deliver_ready=0 adds one cycle of latency; deliver_data is stable throughout.
- Duplicate frame at edge k: CHECK k+1, ack_send=1 in k+2, IDLE k+3.
- Corrupted frame: no output change except err_cnt, visible from cycle k+1.
- Earliest next frame acceptance: the cycle following the ACK state.

## Structure
- Shared package saw_pkg: state encoding for receiver states, default SEQ_W/DATA_W constants shared with the transmitter, and a frame-field layout typedef for seq/data/err.
- One sub-module: sat_counter (CNT_W, inc, count), instantiated three times for err_cnt, dup_cnt, drop_cnt.

## Test plan
- Reset, then frame seq=0, data=0xA5, err=0, deliver_ready=1 -> deliver_valid in cycle k+2 with 0xA5; ack_send pulse in k+3 with ack_seq=1.
- Next frame seq=0 (duplicate, ACK lost) -> no deliver_valid; ack_send in k+2 with ack_seq=1; dup_cnt=1.
- Frame seq=1, err=1 -> no delivery, no ACK, err_cnt=1, Rn stays 1; resend with err=0 -> delivered, ack_seq=0 (wrap).
- deliver_ready held 0 for 5 cycles -> deliver_valid and data stable for 5 cycles, ACK one cycle after ready rises; frm_valid pulse during stall -> drop_cnt=1, state unaffected.
- 300 corrupted frames with CNT_W=8 -> err_cnt saturates at 255.
- rstn asserted while in DELIVER -> next cycle IDLE, deliver_valid=0, Rn=0, counters 0, no ack_send.
